// File: rtl/control_sequencer.sv
// Three-phase instruction sequencer with HALT, memory wait on loads and a
// bounded return-stack pointer whose faults halt the machine.
module control_sequencer #(
  parameter int SP_W     = 3,
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      inst,
  input  logic            eq,
  input  logic            mem_ready,
  input  logic            run,
  output logic [2:0]      state,
  output logic            acc_load,
  output logic            e,
  output logic            wr_en,
  output logic            pc_load,
  output logic            pc_inc,
  output logic            push,
  output logic            pop,
  output logic [SP_W-1:0] sp,
  output logic            stk_err,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_HALT  = 3'b000,
    S_FETCH = 3'b001,
    S_EXEC1 = 3'b010,
    S_EXEC2 = 3'b100
  } phase_e;

  phase_e          state_q, state_d;
  logic [SP_W-1:0] sp_q, sp_d;
  logic            stk_err_q, stk_err_d;

  logic op_jeq, op_sta, op_jmp, op_stp, op_lda, op_jms, op_bbl, op_ldr, op_load;
  logic full, empty, fault;

  assign op_jeq  = (inst[3:1] == 3'b000);
  assign op_sta  = (inst == 4'b0010);
  assign op_jmp  = (inst == 4'b0011);
  assign op_stp  = (inst == 4'b0100);
  assign op_lda  = (inst == 4'b0101);
  assign op_jms  = (inst == 4'b0110);
  assign op_bbl  = (inst == 4'b0111);
  assign op_ldr  = (inst == 4'b1101);
  assign op_load = op_lda | op_ldr;

  // The top stack slot is never used, so the pointer cannot wrap.
  assign full  = (sp_q == {SP_W{1'b1}});
  assign empty = (sp_q == {SP_W{1'b0}});
  assign fault = (op_jms & full) | (op_bbl & empty);

  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    stk_err_d = stk_err_q;
    acc_load  = 1'b0;
    e         = 1'b0;
    wr_en     = 1'b0;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    case (state_q)
      S_HALT: begin
        if (run) state_d = S_FETCH;
        else     state_d = S_HALT;
      end
      S_FETCH: begin
        e       = op_load;
        state_d = S_EXEC1;
      end
      S_EXEC1: begin
        e       = op_load;
        wr_en   = op_sta;
        push    = op_jms & ~full;
        pop     = op_bbl & ~empty;
        pc_load = op_jmp | (op_jeq & ~eq) | push | pop;
        pc_inc  = ~(op_stp | pc_load | fault);
        if (push)      sp_d = sp_q + SP_W'(1);
        else if (pop)  sp_d = sp_q - SP_W'(1);
        else           sp_d = sp_q;
        stk_err_d = stk_err_q | fault;
        if (op_stp | fault) state_d = S_HALT;
        else                state_d = S_EXEC2;
      end
      S_EXEC2: begin
        e = op_load;
        if (MEM_WAIT && op_load && !mem_ready) begin
          state_d = S_EXEC2;
        end else begin
          acc_load = op_load;
          state_d  = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      sp_q      <= {SP_W{1'b0}};
      stk_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sp_q      <= sp_d;
      stk_err_q <= stk_err_d;
    end
  end

  assign state   = state_q;
  assign sp      = sp_q;
  assign stk_err = stk_err_q;
  assign halted  = (state_q == S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer (SP_W=2) with a phase-level reference
// model checked every cycle plus hand-computed literal checks.
module tb_control_sequencer;
  localparam int SP_W  = 2;
  localparam int DEPTH = 4;

  localparam logic [3:0] JEQ = 4'b0000, STA = 4'b0010, JMP = 4'b0011, STP = 4'b0100;
  localparam logic [3:0] LDA = 4'b0101, JMS = 4'b0110, BBL = 4'b0111, LDR = 4'b1101;
  localparam logic [3:0] NOP = 4'b1111;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      inst = NOP;
  logic            eq = 1'b0, mem_ready = 1'b0, run = 1'b0;
  logic [2:0]      state;
  logic            acc_load, e, wr_en, pc_load, pc_inc, push, pop, stk_err, halted;
  logic [SP_W-1:0] sp;

  control_sequencer #(.SP_W(SP_W), .MEM_WAIT(1'b1)) dut (
    .clk(clk), .rst(rst), .inst(inst), .eq(eq), .mem_ready(mem_ready), .run(run),
    .state(state), .acc_load(acc_load), .e(e), .wr_en(wr_en), .pc_load(pc_load),
    .pc_inc(pc_inc), .push(push), .pop(pop), .sp(sp), .stk_err(stk_err), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  // Reference model: phase 0=HALT 1=FETCH 2=EXEC1 3=EXEC2, sp as a plain count.
  int   m_ph, m_sp, n_ph, n_sp;
  bit   m_err, n_err, m_valid = 1'b0;
  bit   is_ld, is_jeq, is_full, is_empty, x_fault;
  bit   x_acc, x_e, x_wr, x_pl, x_pi, x_pu, x_po;
  logic [2:0]  x_state;
  logic [13:0] x_vec, g_vec;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_ph = 1; m_sp = 0; m_err = 1'b0; m_valid = 1'b1;
      end else if (m_valid) begin
        m_ph = n_ph; m_sp = n_sp; m_err = n_err;
      end
      @(negedge clk);
      if (m_valid) begin
        is_ld    = (inst == LDA) || (inst == LDR);
        is_jeq   = (inst == 4'b0000) || (inst == 4'b0001);
        is_full  = (m_sp == DEPTH - 1);
        is_empty = (m_sp == 0);
        x_fault  = 1'b0;
        {x_acc, x_wr, x_pl, x_pi, x_pu, x_po} = 6'b000000;
        x_e   = (m_ph != 0) && is_ld;
        n_ph  = m_ph; n_sp = m_sp; n_err = m_err;
        if (m_ph == 0) begin
          if (run) n_ph = 1;
        end else if (m_ph == 1) begin
          n_ph = 2;
        end else if (m_ph == 2) begin
          x_fault = ((inst == JMS) && is_full) || ((inst == BBL) && is_empty);
          x_wr = (inst == STA);
          x_pu = (inst == JMS) && !is_full;
          x_po = (inst == BBL) && !is_empty;
          x_pl = (inst == JMP) || (is_jeq && !eq) || x_pu || x_po;
          x_pi = !((inst == STP) || x_pl || x_fault);
          if (x_pu) n_sp = m_sp + 1;
          if (x_po) n_sp = m_sp - 1;
          if (x_fault) n_err = 1'b1;
          n_ph = ((inst == STP) || x_fault) ? 0 : 3;
        end else begin
          if (is_ld && !mem_ready) begin
            n_ph = 3;
          end else begin
            x_acc = is_ld;
            n_ph  = 1;
          end
        end
        x_state = (m_ph == 0) ? 3'b000 : (3'b001 << (m_ph - 1));
        x_vec = {x_state, x_acc, x_e, x_wr, x_pl, x_pi, x_pu, x_po, 2'(m_sp), m_err, (m_ph == 0)};
        g_vec = {state, acc_load, e, wr_en, pc_load, pc_inc, push, pop, sp, stk_err, halted};
        chk("cycle", 32'(g_vec), 32'(x_vec));
      end
    end
  end

  initial begin
    // Reset, then LDA with memory ready.
    nxt; rst = 1'b0; inst = LDA; mem_ready = 1'b1;
    smp; chk("rst_state", state, 3'b001); chk("rst_sp", sp, 2'd0);
    chk("rst_err", stk_err, 1'b0); chk("rst_halted", halted, 1'b0);
    chk("rst_pc_inc", pc_inc, 1'b0); chk("lda_e", e, 1'b1);
    nxt; smp; chk("lda_e1", state, 3'b010); chk("lda_inc", pc_inc, 1'b1); chk("lda_acc1", acc_load, 1'b0);
    nxt; smp; chk("lda_e2", state, 3'b100); chk("lda_acc2", acc_load, 1'b1);
    // LDR waiting three cycles on memory.
    nxt; inst = LDR; mem_ready = 1'b0;
    smp; chk("ldr_fetch", state, 3'b001); chk("ldr_acc0", acc_load, 1'b0);
    nxt; smp; chk("ldr_inc", pc_inc, 1'b1);
    for (int k = 0; k < 3; k++) begin
      nxt; smp; chk("ldr_wait", state, 3'b100); chk("ldr_wait_acc", acc_load, 1'b0);
    end
    nxt; mem_ready = 1'b1;
    smp; chk("ldr_e2_4", state, 3'b100); chk("ldr_acc", acc_load, 1'b1);
    // JEQ both ways.
    nxt; inst = JEQ; eq = 1'b0;
    smp; chk("ldr_done", state, 3'b001);
    nxt; smp; chk("jeq0_load", pc_load, 1'b1); chk("jeq0_inc", pc_inc, 1'b0);
    nxt; nxt; eq = 1'b1;
    nxt; smp; chk("jeq1_load", pc_load, 1'b0); chk("jeq1_inc", pc_inc, 1'b1);
    // STA with run asserted, which must be ignored outside HALT.
    nxt; nxt; inst = STA; run = 1'b1;
    nxt; smp; chk("sta_wr", wr_en, 1'b1); chk("sta_run_ign", state, 3'b010);
    nxt; nxt; inst = JMS; run = 1'b0;
    // Three JMS fill the stack; the fourth faults.
    for (int k = 0; k < 3; k++) begin
      nxt; smp; chk("jms_push", push, 1'b1); chk("jms_load", pc_load, 1'b1);
      nxt; smp; chk("jms_sp", sp, 32'(k + 1));
      nxt;
    end
    nxt; smp; chk("ovf_push", push, 1'b0); chk("ovf_load", pc_load, 1'b0); chk("ovf_inc", pc_inc, 1'b0);
    nxt; smp; chk("ovf_state", state, 3'b000); chk("ovf_err", stk_err, 1'b1); chk("ovf_sp", sp, 2'd3);
    nxt; run = 1'b1;
    smp; chk("ovf_hold", halted, 1'b1);
    nxt; run = 1'b0; inst = BBL;
    smp; chk("resume_state", state, 3'b001); chk("resume_err", stk_err, 1'b1);
    // Three BBL drain the stack; the fourth underflows.
    for (int k = 0; k < 3; k++) begin
      nxt; smp; chk("bbl_pop", pop, 1'b1); chk("bbl_load", pc_load, 1'b1);
      nxt; smp; chk("bbl_sp", sp, 32'(2 - k));
      nxt;
    end
    nxt; smp; chk("unf_pop", pop, 1'b0); chk("unf_load", pc_load, 1'b0);
    nxt; smp; chk("unf_halted", halted, 1'b1); chk("unf_err", stk_err, 1'b1); chk("unf_sp", sp, 2'd0);
    nxt; rst = 1'b1;
    nxt; rst = 1'b0; inst = STP;
    smp; chk("rst2_state", state, 3'b001); chk("rst2_err", stk_err, 1'b0); chk("rst2_sp", sp, 2'd0);
    // STP then five HALT cycles before resuming.
    nxt; smp; chk("stp_inc", pc_inc, 1'b0); chk("stp_load", pc_load, 1'b0);
    nxt; smp; chk("stp_halt", state, 3'b000);
    for (int k = 0; k < 4; k++) begin
      nxt; if (k == 3) run = 1'b1;
      smp; chk("stp_hold", state, 3'b000); chk("stp_inc0", pc_inc, 1'b0);
    end
    nxt; run = 1'b0; inst = LDR; mem_ready = 1'b0;
    smp; chk("stp_resume", state, 3'b001);
    // Reset overrides a pending memory wait.
    nxt; nxt; nxt; smp; chk("wait_pend", state, 3'b100);
    rst = 1'b0;
    nxt; rst = 1'b1;
    nxt; rst = 1'b0; inst = NOP;
    smp; chk("wait_rst", state, 3'b001);
    repeat (6) begin nxt; smp; end
    chk("nop_sp", sp, 2'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
